// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: prefetching fetch stage with an in-order {pc, inst} FIFO and redirect flush
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int            PW     = $clog2(DEPTH);
    localparam int            CW     = PW + 1;
    localparam logic [CW+1:0] LIMIT  = (CW+2)'(DEPTH);
    localparam logic [31:0]   RST_PC = RESET_PC & ~32'd3;

    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, new_pc;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, disc_q, disc_d;
    logic [31:0]   mem_pc_q [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [CW+1:0] in_use;
    logic          grant, push, drop, pop, live;

    always_comb begin
        new_pc    = redirect_pc & ~32'd3;
        in_use    = {2'b00, count_q} + {2'b00, outst_q} + {2'b00, disc_q};
        imem_req  = ~rst & ~redirect & (in_use < LIMIT);
        imem_addr = fetch_pc_q;
        out_valid = count_q != '0;
        out_inst  = out_valid ? mem_inst_q[rd_ptr_q] : '0;
        out_pc    = out_valid ? mem_pc_q[rd_ptr_q] : '0;
        grant     = imem_req & imem_gnt;
        // a response with nothing in flight is a protocol violation and is ignored
        live      = (disc_q != '0) | (outst_q != '0);
        drop      = imem_rvalid & (disc_q != '0);
        push      = imem_rvalid & (disc_q == '0) & (outst_q != '0) & ~redirect;
        pop       = out_valid & out_ready;
        fetch_pc_d = redirect ? new_pc : fetch_pc_q + (grant ? 32'd4 : 32'd0);
        resp_pc_d  = redirect ? new_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
        rd_ptr_d   = redirect ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d   = redirect ? '0 : wr_ptr_q + PW'(push);
        count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        outst_d    = redirect ? '0 : outst_q + CW'(grant) - CW'(push);
        disc_d     = redirect ? disc_q + outst_q - CW'(imem_rvalid & live) : disc_q - CW'(drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RST_PC;
            resp_pc_q  <= RST_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            mem_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table, directed and random checks of inst_fetch_queue against a queue-level model
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 0, rst = 1, imem_gnt = 0, imem_rvalid = 0, redirect = 0, out_ready = 0;
    logic        imem_req, out_valid;
    logic [31:0] imem_rdata = 0, redirect_pc = 0, imem_addr, out_inst, out_pc;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic rst; logic rdy; logic ev; logic [31:0] epc; logic ereq; } vec_t;

    entry_t      q[$];
    logic [31:0] kept[$];
    pend_t       pend[$];
    logic [31:0] seen[$];
    logic [31:0] m_fetch = RESET_PC, key = 0;
    int          n_disc = 0, cyc = 0, lat_min = 1, lat_max = 1, rv_pct = 100;
    int          n_tests = 0, n_fail = 0;
    logic        exp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive the memory response, then compare every output with the model.
    task automatic pre();
        imem_rvalid = 0;
        imem_rdata  = $urandom;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1;
            imem_rdata  = pend[0].addr ^ key;
        end
        #1;
        exp_req = !rst && !redirect && (q.size() + kept.size() + n_disc < DEPTH);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_pc", out_pc, q.size() > 0 ? q[0].pc : 32'h0);
        chk("out_inst", out_inst, q.size() > 0 ? q[0].inst : 32'h0);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_fetch);
        if (!rst && !redirect && out_valid && out_ready) seen.push_back(out_pc);
    endtask

    task automatic post();
        logic [31:0] a;
        if (rst) begin
            q.delete(); kept.delete(); pend.delete();
            n_disc  = 0;
            m_fetch = RESET_PC;
        end else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (redirect) begin
                n_disc += kept.size() - (imem_rvalid ? 1 : 0);
                kept.delete(); q.delete();
                m_fetch = redirect_pc & ~32'd3;
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (imem_rvalid) begin
                    if (n_disc > 0) n_disc--;
                    else begin
                        a = kept.pop_front();
                        q.push_back('{a, a ^ key});
                    end
                end
                if (exp_req && imem_gnt) begin
                    kept.push_back(m_fetch);
                    pend.push_back('{m_fetch, cyc + int'($urandom_range(lat_max, lat_min))});
                    m_fetch += 4;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst = 1; redirect = 0;
        tick();
        rst = 0;
    endtask

    function automatic logic [31:0] seen_at(input int i);
        return seen.size() > i ? seen[i] : 32'hFFFF_FFFF;
    endfunction

    vec_t vecs[15];
    int   grants, bad;
    logic [31:0] exp_disc;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs = '{
            '{1, 0, 0, 32'd0, 0}, '{0, 0, 0, 32'd0, 1}, '{0, 0, 0, 32'd0, 1},
            '{0, 0, 1, 32'd0, 1}, '{0, 0, 1, 32'd0, 1}, '{0, 0, 1, 32'd0, 0},
            '{0, 0, 1, 32'd0, 0}, '{0, 0, 1, 32'd0, 0}, '{0, 1, 1, 32'd0, 0},
            '{0, 1, 1, 32'd4, 1}, '{0, 1, 1, 32'd8, 1}, '{0, 1, 1, 32'd12, 1},
            '{0, 1, 1, 32'd16, 1}, '{0, 1, 1, 32'd20, 1}, '{0, 1, 1, 32'd24, 1}
        };
        imem_gnt = 1;
        grants   = 0;
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            out_ready = vecs[i].rdy;
            pre();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].ev ? vecs[i].epc : 32'h0);
            chk($sformatf("vec%0d_inst", i), out_inst, vecs[i].ev ? vecs[i].epc : 32'h0);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].ereq));
            if (i < 8 && imem_req && imem_gnt) grants++;
            post();
        end
        chk("backpressure_grants", grants, 4);

        // stale responses in flight across a redirect to an unaligned target
        key = 32'h5A5A_0000; lat_min = 3; lat_max = 3;
        do_reset();
        out_ready = 1;
        tick(); tick();
        imem_gnt = 0; redirect = 1; redirect_pc = 32'h0000_0103;
        seen.delete();
        tick();
        redirect = 0; imem_gnt = 1;
        repeat (20) tick();
        chk("redir_first_pc", seen_at(0), 32'h100);
        chk("redir_second_pc", seen_at(1), 32'h104);

        // redirect, response and pop in the same cycle
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (6) tick();
        redirect = 1; redirect_pc = 32'h0000_0400;
        pre();
        chk("simul_setup", {30'd0, imem_rvalid, out_valid}, 32'd3);
        exp_disc = n_disc + kept.size() - (imem_rvalid ? 1 : 0);
        post();
        redirect = 0;
        chk("simul_disc", 32'(dut.disc_q), exp_disc);
        chk("simul_count", 32'(dut.count_q), 32'd0);
        repeat (10) tick();

        // back-to-back redirects
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (5) tick();
        seen.delete();
        redirect = 1; redirect_pc = 32'h200; tick();
        redirect_pc = 32'h300; tick();
        redirect = 0;
        repeat (12) tick();
        chk("b2b_first_pc", seen_at(0), 32'h300);
        bad = 0;
        foreach (seen[i]) if (seen[i][31:8] == 24'h2) bad++;
        chk("b2b_no_0x200", bad, 0);

        // reset with entries queued and responses outstanding
        lat_min = 3; lat_max = 3; out_ready = 0;
        do_reset();
        repeat (5) tick();
        rst = 1;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_addr", imem_addr, RESET_PC);
        chk("mrst_count", 32'(dut.count_q), 32'd0);
        chk("mrst_outst", 32'(dut.outst_q), 32'd0);
        chk("mrst_disc", 32'(dut.disc_q), 32'd0);
        rst = 0; out_ready = 1;
        seen.delete();
        repeat (12) tick();
        chk("mrst_resume_pc", seen_at(0), RESET_PC);

        // random traffic
        key = 32'hC3C3_0F0F; lat_min = 1; lat_max = 4; rv_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom % 200) == 0;
            redirect    = !rst && ($urandom % 30) == 0;
            redirect_pc = $urandom;
            out_ready   = ($urandom % 4) != 0;
            imem_gnt    = ($urandom % 4) != 0;
            tick();
        end
        rst = 0; redirect = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
